// File: rtl/priority_decoder_seq.sv
// -----------------------------------------------------------------------------
// priority_decoder_seq
//
// Turns the 8-bit code stream of the 16-input priority encoder back into a
// 16-line one-hot bus. Codes are queued in a small FIFO. Each queued code is
// replayed on onehot_out for HOLD_CYCLES clock cycles, and the next queued
// code follows with no gap cycle. Typical uses are loopback self-test of the
// encoder path and driving LEDs or strobes from encoded events.
//
// Handshake (code_valid / code_ready):
//   A code is transferred on a rising clk edge where code_valid and code_ready
//   are both high. code_ready is high whenever the FIFO is not full, and it
//   does not depend on a pop in the same cycle. While code_ready is low the
//   source must keep code_valid and code_in stable. Codes that are not
//   recognised still complete the handshake, but they are dropped and they
//   set err_sticky.
//
// Code classes:
//   8'h00..8'h0F : index n, replayed as 16'h1 << n
//   NONE_CODE    : "nothing active", replayed as 16'h0000 with out_active=1
//   anything else: dropped, sets err_sticky
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   code_in     in   [7:0] encoded priority code
//   code_valid  in   code_in is valid this cycle
//   code_ready  out  a code can be accepted this cycle (FIFO not full)
//   onehot_out  out  [15:0] registered decoded pattern
//   out_active  out  a code (including NONE_CODE) is being held
//   busy        out  out_active or FIFO not empty
//   fill        out  FIFO occupancy, 0..DEPTH
//   err_sticky  out  an unrecognised code arrived since the last clear
//   err_clr     in   synchronous clear of err_sticky (a new error wins)
// -----------------------------------------------------------------------------
module priority_decoder_seq #(
  parameter int unsigned DEPTH       = 4,      // power of two, >= 2
  parameter int unsigned HOLD_CYCLES = 4,      // >= 1
  parameter logic [7:0]  NONE_CODE   = 8'hF0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   code_in,
  input  logic                         code_valid,
  output logic                         code_ready,
  output logic [15:0]                  onehot_out,
  output logic                         out_active,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         err_sticky,
  input  logic                         err_clr
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  // A one-cycle hold still needs a one-bit counter so the datapath stays legal.
  localparam int unsigned CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_EMPTY  = '0;

  // FIFO entries are stored pre-classified: bit 4 marks NONE_CODE, and bits
  // 3:0 hold the index. Unrecognised codes never reach the FIFO.
  localparam int unsigned ENTRY_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic               err_q,     err_d;

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [15:0]        onehot_q,  onehot_d;
  logic               active_q,  active_d;

  // ---------------------------------------------------------------------------
  // Input classification and handshake
  // ---------------------------------------------------------------------------
  logic               accept;
  logic               code_is_none;
  logic               code_is_idx;
  logic               push;
  logic               err_set;
  logic               pop;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  always_comb begin
    fifo_empty   = (fill_q == FILL_EMPTY);
    code_ready   = (fill_q != FILL_FULL);
    accept       = code_valid & code_ready;
    // NONE_CODE is checked first so that a NONE_CODE value that happens to
    // fall in 0..15 still decodes to all zeros.
    code_is_none = (code_in == NONE_CODE);
    code_is_idx  = (code_in[7:4] == 4'h0) & ~code_is_none;
    push         = accept & (code_is_none | code_is_idx);
    err_set      = accept & ~(code_is_none | code_is_idx);
    push_entry   = {code_is_none, code_in[3:0]};
    head_entry   = mem_q[rd_ptr_q];
  end

  // Map a stored entry onto the 16-line bus.
  function automatic logic [15:0] decode_entry(input logic [ENTRY_W-1:0] e);
    logic [15:0] pat;
    pat = 16'h0000;
    if (!e[4]) begin
      pat = 16'h0001 << e[3:0];
    end
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Replay FSM next-state logic
  //
  // IDLE waits for a queued entry. HOLD keeps the pattern for HOLD_CYCLES
  // cycles. On the last cycle of a hold, the next entry is loaded at once if
  // one is queued, so back-to-back patterns have no zero gap between them.
  // The pop decision looks only at the registered fill. A code pushed in the
  // same cycle is therefore popped one edge later, and there is no bypass.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    active_d = active_q;
    pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          onehot_d = decode_entry(head_entry);
          cnt_d    = HOLD_RELOAD;
          active_d = 1'b1;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          onehot_d = decode_entry(head_entry);
          cnt_d    = HOLD_RELOAD;
          active_d = 1'b1;
        end else begin
          onehot_d = 16'h0000;
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end

      default: begin
        onehot_d = 16'h0000;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer / occupancy and error flag next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // A push only happens when the FIFO is not full, and a pop only happens
    // when it is not empty, so fill stays within 0..DEPTH.
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    // A new error in the same cycle as err_clr keeps the flag set.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // FIFO storage is not reset. Reset clears the pointers and fill, so stale
  // contents can never be read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  // Replay FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= 16'h0000;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      active_q <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign onehot_out = onehot_q;
  assign out_active = active_q;
  assign busy       = active_q | ~fifo_empty;
  assign fill       = fill_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_priority_decoder_seq
//
// Directed and random stimulus for priority_decoder_seq. A behavioural model
// tracks the queued codes in a SystemVerilog queue. It also keeps the code
// currently on the bus, with the number of cycles it has left. After every
// clock edge, all of the DUT outputs are compared against this model.
// -----------------------------------------------------------------------------
module tb_priority_decoder_seq;

  localparam int          DEPTH = 4;
  localparam int          HOLD  = 4;
  localparam logic [7:0]  NONE  = 8'hF0;
  localparam int          FW    = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic [7:0]    code_in;
  logic          code_valid;
  logic          code_ready;
  logic [15:0]   onehot_out;
  logic          out_active;
  logic          busy;
  logic [FW-1:0] fill;
  logic          err_sticky;
  logic          err_clr;

  priority_decoder_seq #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .NONE_CODE   (NONE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .onehot_out (onehot_out),
    .out_active (out_active),
    .busy       (busy),
    .fill       (fill),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_q[$];       // accepted codes that are waiting to be shown
  logic [15:0] m_pat;          // pattern expected on the bus
  bit          m_active;
  int          m_remain;       // cycles the current pattern is still shown
  bit          m_err;

  int          tests_run;
  int          tests_failed;

  bit          track_en;
  logic [15:0] prev_oh;
  logic [15:0] obs_q[$];

  function automatic logic [15:0] ref_decode(input logic [7:0] c);
    if (c == NONE) return 16'h0000;
    return 16'(32'd1 << c);
  endfunction

  function automatic bit is_pushed(input logic [7:0] c);
    return (c < 8'd16) || (c == NONE);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pat    = 16'h0000;
    m_active = 1'b0;
    m_remain = 0;
    m_err    = 1'b0;
  endtask

  // One rising edge. The code to show is chosen from the queue as it stood
  // before the edge. A code accepted at this same edge joins the queue after
  // that choice is made.
  task automatic model_edge(input logic v, input logic [7:0] c, input logic clr);
    bit acc;
    acc = v && (exp_q.size() != DEPTH);
    if (!m_active || m_remain == 1) begin
      if (exp_q.size() > 0) begin
        m_pat    = ref_decode(exp_q.pop_front());
        m_active = 1'b1;
        m_remain = HOLD;
      end else begin
        m_pat    = 16'h0000;
        m_active = 1'b0;
        m_remain = 0;
      end
    end else begin
      m_remain = m_remain - 1;
    end
    if (acc && is_pushed(c)) exp_q.push_back(c);
    if (acc && !is_pushed(c)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".onehot"}, 32'(onehot_out), 32'(m_pat));
    check({tag, ".active"}, 32'(out_active), 32'(m_active));
    check({tag, ".busy"},   32'(busy),       32'(m_active || exp_q.size() > 0));
    check({tag, ".fill"},   32'(fill),       32'(exp_q.size()));
    check({tag, ".err"},    32'(err_sticky), 32'(m_err));
    check({tag, ".ready"},  32'(code_ready), 32'(exp_q.size() != DEPTH));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    code_valid = v;
    code_in    = c;
    err_clr    = clr;
  endtask

  // Run one clock edge, update the model, then compare 1 time unit later.
  task automatic cycle(input string tag);
    logic       sv;
    logic [7:0] sc;
    logic       sclr;
    sv   = code_valid;
    sc   = code_in;
    sclr = err_clr;
    @(posedge clk);
    model_edge(sv, sc, sclr);
    #1;
    check_all(tag);
    if (track_en) begin
      if (onehot_out !== prev_oh && onehot_out != 16'h0000) obs_q.push_back(onehot_out);
      prev_oh = onehot_out;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int nxt;
    int budget;
    int r;
    logic [7:0] rc;

    tests_run    = 0;
    tests_failed = 0;
    track_en     = 1'b0;
    prev_oh      = 16'h0000;
    rst_n        = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single code 8'h05
    drive(1'b1, 8'h05, 1'b0);
    cycle("single_push");
    check("single_e0_onehot", 32'(onehot_out), 32'h0);
    check("single_e0_fill",   32'(fill),       32'd1);
    drive(1'b0, 8'h00, 1'b0);
    cycle("single");
    check("single_e1_onehot", 32'(onehot_out), 32'h0020);
    repeat (6) cycle("single");
    check("single_end_busy", 32'(busy), 32'd0);

    // Back-to-back 8'h0F then 8'h00
    drive(1'b1, 8'h0F, 1'b0);
    cycle("b2b_push0");
    drive(1'b1, 8'h00, 1'b0);
    cycle("b2b_push1");
    check("b2b_first", 32'(onehot_out), 32'h8000);
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) cycle("b2b");
    check("b2b_last_of_first", 32'(onehot_out), 32'h8000);
    cycle("b2b");
    check("b2b_no_gap", 32'(onehot_out), 32'h0001);
    repeat (6) cycle("b2b");

    // NONE_CODE
    drive(1'b1, NONE, 1'b0);
    cycle("none_push");
    drive(1'b0, 8'h00, 1'b0);
    cycle("none");
    check("none_onehot", 32'(onehot_out), 32'h0);
    check("none_active", 32'(out_active), 32'd1);
    repeat (5) cycle("none");
    check("none_err", 32'(err_sticky), 32'd0);

    // Invalid codes and err_clr priority
    drive(1'b1, 8'h10, 1'b0);
    cycle("inv_push");
    check("inv_fill", 32'(fill),       32'd0);
    check("inv_err",  32'(err_sticky), 32'd1);
    drive(1'b1, 8'h3A, 1'b1);
    cycle("inv_set_clr");
    check("inv_set_wins", 32'(err_sticky), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    cycle("inv_clr");
    check("inv_cleared", 32'(err_sticky), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) cycle("inv_idle");

    // Full FIFO: codes 0..7, each held on the input until it is accepted
    track_en = 1'b1;
    prev_oh  = onehot_out;
    obs_q.delete();
    nxt      = 0;
    budget   = 0;
    while (nxt < 8 && budget < 100) begin
      bit acc;
      drive(1'b1, 8'(nxt), 1'b0);
      acc = (exp_q.size() != DEPTH);
      cycle("full");
      if (acc) nxt++;
      budget++;
    end
    check("full_all_accepted", 32'(nxt), 32'd8);
    drive(1'b0, 8'h00, 1'b0);
    repeat (40) cycle("full_drain");
    track_en = 1'b0;
    check("full_obs_count", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 16'hxxxx;
      check($sformatf("full_order%0d", i), 32'(o), 32'(16'(32'd1 << i)));
    end

    // Reset in the middle of a hold, with two codes queued
    drive(1'b1, 8'h09, 1'b0);
    cycle("rst_push0");
    drive(1'b1, 8'h0A, 1'b0);
    cycle("rst_push1");
    drive(1'b1, 8'h0B, 1'b0);
    cycle("rst_push2");
    drive(1'b0, 8'h00, 1'b0);
    check("rst_pre_fill",   32'(fill),       32'd2);
    check("rst_pre_onehot", 32'(onehot_out), 32'h0200);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_onehot", 32'(onehot_out), 32'h0);
    check("rst_async_fill",   32'(fill),       32'd0);
    check("rst_async_active", 32'(out_active), 32'd0);
    check("rst_async_busy",   32'(busy),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("rst_release");
    drive(1'b1, 8'h03, 1'b0);
    cycle("rst_after_push");
    drive(1'b0, 8'h00, 1'b0);
    cycle("rst_after");
    check("rst_after_onehot", 32'(onehot_out), 32'h0008);
    repeat (6) cycle("rst_after");

    // Random traffic
    repeat (400) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      rc = 8'($urandom_range(0, 15));
      else if (r == 6) rc = NONE;
      else if (r == 7) rc = 8'($urandom_range(0, 255));
      else             rc = 8'($urandom_range(0, 15));
      drive(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 7) == 0));
      cycle("rand");
    end
    drive(1'b0, 8'h00, 1'b0);
    repeat (30) cycle("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_decoder_seq.md
Name: priority_decoder_seq

Overview:
- Inverse of the team's 16-input priority encoder: consumes the encoder's 8-bit code stream and regenerates a 16-bit one-hot line.
- Codes enter through a valid/ready handshake and queue in a small FIFO.
- Each code drives one one-hot bit for a programmable number of cycles, then the next queued code follows.
- Sits on the output side of the encoder path, replaying encoded events onto a 16-line bus, e.g. for loopback self-test or LED/strobe driving.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 4: cycles each decoded pattern is held on onehot_out; minimum 1.
- NONE_CODE, 8'hF0: code meaning "no input active".

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- code_in  input  8  encoded priority code.
- code_valid  input  1  code_in is valid this cycle.
- code_ready  output  1  block can accept a code this cycle.
- onehot_out  output  16  decoded one-hot pattern, registered.
- out_active  output  1  a code (including NONE_CODE) is currently being held.
- busy  output  1  out_active OR FIFO not empty.
- fill  output  clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- err_sticky  output  1  an invalid code has been received since the last clear.
- err_clr  input  1  synchronous clear of err_sticky.

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately:
  - onehot_out=0, out_active=0, busy=0, fill=0, err_sticky=0.
  - FIFO pointers cleared, FSM forced to IDLE, hold counter=0.
  - A reset in the middle of a hold drops the pattern at once and discards all queued codes.
- code_ready = (fill != DEPTH). It does not depend on a same-cycle pop.
- Accept condition: code_valid AND code_ready at a rising edge. code_valid while not ready is ignored; the source must hold the code.
- Code classes:
  - 8'h00..8'h0F: valid index, pushed.
  - NONE_CODE: valid, pushed; decodes to all zeros.
  - Anything else: accepted (handshake completes) but not pushed; err_sticky set at that edge.
- err_sticky: set has priority over err_clr in the same cycle.
- Decode: index n gives onehot_out = 16'h1 << n. NONE_CODE gives 16'h0000.
- FSM has two states, IDLE and HOLD.
  - IDLE: if the FIFO is non-empty at an edge, pop the head, load onehot_out, set hold counter to HOLD_CYCLES-1, set out_active=1, go to HOLD.
  - HOLD, counter != 0: decrement the counter; onehot_out unchanged.
  - HOLD, counter == 0 and FIFO non-empty: pop and reload at that edge. Back-to-back patterns have no gap cycle.
  - HOLD, counter == 0 and FIFO empty: onehot_out=0, out_active=0, go to IDLE.
- Latency:
  - Code accepted at edge E0 into an empty FIFO in IDLE: onehot_out shows the pattern from edge E1.
  - The pattern is held exactly HOLD_CYCLES cycles.
  - It is cleared at edge E1+HOLD_CYCLES if nothing is queued.
- Simultaneous push and pop:
  - Both occur; fill is unchanged.
  - A push into an empty FIFO in the same cycle as the IDLE check is popped on the next edge; there is no bypass.
- FIFO order is strict first-in first-out.
- Pointers wrap modulo DEPTH.
- fill never exceeds DEPTH and never underflows.

Test Plan:
- Single code: push 8'h05 after reset → onehot_out=16'h0020 from edge E1 for exactly 4 cycles, then 16'h0000; out_active follows the same window; busy=0 afterwards.
- Back-to-back: push 8'h0F then 8'h00 on consecutive cycles → 16'h8000 for 4 cycles, then immediately 16'h0001 for 4 cycles, no zero cycle between them.
- None code: push 8'hF0 → onehot_out stays 16'h0000 while out_active=1 for 4 cycles; err_sticky stays 0.
- Invalid code: push 8'h10 → handshake completes, fill stays 0, no output; err_sticky=1. Assert err_clr together with a second 8'h3A → err_sticky remains 1. Assert err_clr alone → err_sticky=0.
- Full FIFO: hold code_valid with codes 0,1,2,...,7 every cycle → code_ready drops when fill=4. Outputs must appear in order 16'h0001, 16'h0002, ... with none lost or duplicated. code_ready returns high the cycle after each pop.
- Reset mid-hold: with 8'h09 held and 2 codes queued, pulse rst_n low → onehot_out=0, fill=0, out_active=0 immediately. After release, a new 8'h03 decodes to 16'h0008 normally.
